// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

   localparam int SA_MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sa_state_t;

endpackage

// File: rtl/fa_1b.sv
// Single-bit full adder cell; the only combinational arithmetic in the serial adder.
module fa_1b (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_nb.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through fa_1b, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one bit pair per cycle through fa_1b
// DONE  | one-cycle result-valid pulse; start here is accepted back-to-back
module serial_adder_nb
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   sa_state_t        state;
   sa_state_t        state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] s_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_cout;
   logic             load;
   logic             last;
   logic [WIDTH-1:0] s_full;

   fa_1b u_fa (
      .A    (a_sr[0]),
      .B    (b_sr[0]),
      .Cin  (carry),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   assign load   = (state != RUN) && start;
   assign last   = (state == RUN) && (cnt == CNT_LAST);
   // s_sr keeps the WIDTH-1 sum bits already produced; the current bit completes the word
   assign s_full = {fa_s, s_sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         S     <= '0;
         Cout  <= 1'b0;
      end else if (load) begin
         a_sr  <= A;
         b_sr  <= B;
         s_sr  <= '0;
         carry <= Cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         s_sr  <= s_full[WIDTH-1:1];
         carry <= fa_cout;
         cnt   <= cnt + 1'b1;
         if (last) begin
            S    <= s_full;
            Cout <= fa_cout;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // In the last RUN cycle the carry flop holds the carry into the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Ovf <= 1'b0;
      end else if (last) begin
         Ovf <= carry ^ fa_cout;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder_nb.sv
// Scoreboard bench for serial_adder_nb (WIDTH=8); Ovf is checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_nb;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] S;
   logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         Ovf;
`endif

   int           n_tests = 0;
   int           n_fail = 0;
   exp_t         exp_q[$];
   logic [W-1:0] prev_s = '0;
   logic         prev_c = 1'b0;

   serial_adder_nb #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .Ovf   (Ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no result pending");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum", 32'(S), 32'(e.s));
            chk("cout", 32'(Cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", 32'(Ovf), 32'(e.ovf));
`endif
         end
      end
   end

   // Issued at a negedge; returns at the negedge where done is seen (or after abort/timeout)
   task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input int poke_cycle, input int abort_cycle);
      int   n;
      int   busy_n;
      int   dn;
      bit   hold_ok;
      bit   seen;
      exp_t e;
      A     = a;
      B     = b;
      Cin   = cin;
      start = 1'b1;
      if (abort_cycle == 0) begin
         e.s = es; e.cout = ec; e.ovf = eo;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start   = 1'b0;
      n       = 1;
      busy_n  = 0;
      hold_ok = 1'b1;
      seen    = 1'b0;
      while (n <= 20) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) begin
            busy_n++;
            if (S !== prev_s || Cout !== prev_c) hold_ok = 1'b0;
         end
         if (n == poke_cycle) begin
            A     = 8'hAA;
            B     = 8'h55;
            Cin   = 1'b1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (n == abort_cycle) begin
            rst_n = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_sum", 32'(S), 32'd0);
            chk("abort_cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            chk("abort_ovf", 32'(Ovf), 32'd0);
`endif
            @(negedge clk);
            rst_n  = 1'b1;
            prev_s = '0;
            prev_c = 1'b0;
            dn     = 0;
            repeat (12) begin
               @(negedge clk);
               if (done) dn++;
            end
            chk("no_done_after_abort", 32'(dn), 32'd0);
            chk("idle_after_abort", 32'(busy), 32'd0);
            return;
         end
         @(negedge clk);
         n++;
      end
      if (!seen) $display("FAIL timeout: got no done within 20 cycles expected done");
      chk("latency", 32'(n), 32'd9);
      chk("busy_cycles", 32'(busy_n), 32'd8);
      chk("hold_during_run", 32'(hold_ok), 32'd1);
      prev_s = es;
      prev_c = ec;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(S), 32'd0);
      chk("rst_cout", 32'(Cout), 32'd0);

      run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
      @(negedge clk);
      // back-to-back: second start issued during DONE
      run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0);
      run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 0);
      run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0);
      @(negedge clk);
      run_add(8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1, 0, 0);
      run_add(8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0);
      @(negedge clk);
      // start pulsed mid-run with other operands must be ignored
      run_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 3, 0);
      @(negedge clk);
      run_add(8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0, 0, 4);
      run_add(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
